// File: rtl/mips_isa_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_isa_pkg
//  Description : Shared MIPS ISA definitions for the instruction encoder and
//                the decoder: operation-select enum, primary opcodes, R-type
//                funct codes, field bit positions and word-packing helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package mips_isa_pkg;

    // Operation select carried on op_sel. Values 18..31 are not defined and
    // are reported as illegal by the encoder.
    typedef enum logic [4:0] {
        OP_SLL  = 5'd0,
        OP_JR   = 5'd1,
        OP_MFLO = 5'd2,
        OP_MULT = 5'd3,
        OP_ADD  = 5'd4,
        OP_OR   = 5'd5,
        OP_SLT  = 5'd6,
        OP_J    = 5'd7,
        OP_JAL  = 5'd8,
        OP_BEQ  = 5'd9,
        OP_BNE  = 5'd10,
        OP_ADDI = 5'd11,
        OP_SLTI = 5'd12,
        OP_ANDI = 5'd13,
        OP_ORI  = 5'd14,
        OP_LUI  = 5'd15,
        OP_LW   = 5'd16,
        OP_SW   = 5'd17
    } op_e;

    // Field bit positions inside the 32-bit machine word.
    localparam int c_OPC_LSB   = 26;
    localparam int c_RS_LSB    = 21;
    localparam int c_RT_LSB    = 16;
    localparam int c_RD_LSB    = 11;
    localparam int c_SHAMT_LSB = 6;

    // Primary opcodes.
    localparam logic [5:0] c_OPC_RTYPE = 6'h00;
    localparam logic [5:0] c_OPC_J     = 6'h02;
    localparam logic [5:0] c_OPC_JAL   = 6'h03;
    localparam logic [5:0] c_OPC_BEQ   = 6'h04;
    localparam logic [5:0] c_OPC_BNE   = 6'h05;
    localparam logic [5:0] c_OPC_ADDI  = 6'h08;
    localparam logic [5:0] c_OPC_SLTI  = 6'h0A;
    localparam logic [5:0] c_OPC_ANDI  = 6'h0C;
    localparam logic [5:0] c_OPC_ORI   = 6'h0D;
    localparam logic [5:0] c_OPC_LUI   = 6'h0F;
    localparam logic [5:0] c_OPC_LW    = 6'h23;
    localparam logic [5:0] c_OPC_SW    = 6'h2B;

    // R-type funct codes.
    localparam logic [5:0] c_FN_SLL  = 6'h00;
    localparam logic [5:0] c_FN_JR   = 6'h08;
    localparam logic [5:0] c_FN_MFLO = 6'h12;
    localparam logic [5:0] c_FN_MULT = 6'h18;
    localparam logic [5:0] c_FN_ADD  = 6'h20;
    localparam logic [5:0] c_FN_OR   = 6'h25;
    localparam logic [5:0] c_FN_SLT  = 6'h2A;

    localparam logic [4:0] c_REG_ZERO = 5'd0;

    // R-type word: opcode is always zero.
    function automatic logic [31:0] pack_r(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] shamt,
                                           input logic [5:0] funct);
        return {c_OPC_RTYPE, rs, rt, rd, shamt, funct};
    endfunction

    function automatic logic [31:0] pack_i(input logic [5:0] opc, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

    function automatic logic [31:0] pack_j(input logic [5:0] opc, input logic [25:0] target);
        return {opc, target};
    endfunction

endpackage
`default_nettype wire

// File: rtl/encode_instruction_if.sv
`default_nettype none
// ============================================================================
//  Module      : encode_instruction_if
//  Description : Request and memory-write bundle of the instruction encoder.
//                master : the loader side (drives requests, accepts words)
//                slave  : the encoder (accepts requests, drives words)
//  Signals     : start/base_addr     program start and first word address
//                in_valid/in_ready   request handshake
//                op_sel,rs,rt,rd,shamt,imm,target  symbolic instruction
//                mem_valid/mem_ready/mem_addr/mem_wdata  memory write port
//                illegal, words_written  status
//  Revision    : 1.0  initial release
// ============================================================================
interface encode_instruction_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        op_sel;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [15:0]       imm;
    logic [25:0]       target;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              illegal;
    logic [ADDR_W-1:0] words_written;

    modport slave (
        input  start, base_addr, in_valid, op_sel, rs, rt, rd, shamt, imm, target,
               mem_ready,
        output in_ready, mem_valid, mem_addr, mem_wdata, illegal, words_written
    );

    modport master (
        output start, base_addr, in_valid, op_sel, rs, rt, rd, shamt, imm, target,
               mem_ready,
        input  in_ready, mem_valid, mem_addr, mem_wdata, illegal, words_written
    );
endinterface
`default_nettype wire

// File: rtl/encode_instruction_fields.sv
`default_nettype none
// ============================================================================
//  Module      : encode_fields
//  Description : Combinational packer from a symbolic instruction to a 32-bit
//                MIPS word. Register fields an operation does not use are
//                forced to zero. Unsupported op_sel values raise o_illegal and
//                give a zero word.
//  Config      : ENC_BRANCH_REL_EN - BEQ/BNE offset is computed from the
//                absolute word address in i_target (ADDR_W <= 16) instead of
//                taking i_imm verbatim.
//  Ports       : i_op_sel, i_rs, i_rt, i_rd, i_shamt, i_imm, i_target  fields
//                i_addr     word address assigned to this instruction
//                o_word     encoded instruction
//                o_illegal  op_sel not supported
//  Revision    : 1.0  initial release
// ============================================================================
module encode_fields
    import mips_isa_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  wire logic [4:0]        i_op_sel,
    input  wire logic [4:0]        i_rs,
    input  wire logic [4:0]        i_rt,
    input  wire logic [4:0]        i_rd,
    input  wire logic [4:0]        i_shamt,
    input  wire logic [15:0]       i_imm,
    input  wire logic [25:0]       i_target,
    input  wire logic [ADDR_W-1:0] i_addr,
    output logic      [31:0]       o_word,
    output logic                   o_illegal
);

    logic [15:0] w_br_imm;

`ifdef ENC_BRANCH_REL_EN
    // Offset is relative to the word after the branch; both operands are
    // zero-extended to 16 bits so the difference wraps as two's complement.
    logic [15:0] w_tgt16;
    logic [15:0] w_next16;
    assign w_tgt16  = 16'(i_target[ADDR_W-1:0]);
    assign w_next16 = 16'(i_addr) + 16'd1;
    assign w_br_imm = w_tgt16 - w_next16;
`else
    // The assigned address only matters for relative branches.
    logic w_unused_addr;
    assign w_unused_addr = ^i_addr;
    assign w_br_imm      = i_imm;
`endif

    always_comb begin
        o_word    = '0;
        o_illegal = 1'b0;
        case (i_op_sel)
            OP_SLL:  o_word = pack_r(c_REG_ZERO, i_rt, i_rd, i_shamt, c_FN_SLL);
            OP_JR:   o_word = pack_r(i_rs, c_REG_ZERO, c_REG_ZERO, 5'd0, c_FN_JR);
            OP_MFLO: o_word = pack_r(c_REG_ZERO, c_REG_ZERO, i_rd, 5'd0, c_FN_MFLO);
            OP_MULT: o_word = pack_r(i_rs, i_rt, c_REG_ZERO, 5'd0, c_FN_MULT);
            OP_ADD:  o_word = pack_r(i_rs, i_rt, i_rd, 5'd0, c_FN_ADD);
            OP_OR:   o_word = pack_r(i_rs, i_rt, i_rd, 5'd0, c_FN_OR);
            OP_SLT:  o_word = pack_r(i_rs, i_rt, i_rd, 5'd0, c_FN_SLT);
            OP_J:    o_word = pack_j(c_OPC_J, i_target);
            OP_JAL:  o_word = pack_j(c_OPC_JAL, i_target);
            OP_BEQ:  o_word = pack_i(c_OPC_BEQ, i_rs, i_rt, w_br_imm);
            OP_BNE:  o_word = pack_i(c_OPC_BNE, i_rs, i_rt, w_br_imm);
            OP_ADDI: o_word = pack_i(c_OPC_ADDI, i_rs, i_rt, i_imm);
            OP_SLTI: o_word = pack_i(c_OPC_SLTI, i_rs, i_rt, i_imm);
            OP_ANDI: o_word = pack_i(c_OPC_ANDI, i_rs, i_rt, i_imm);
            OP_ORI:  o_word = pack_i(c_OPC_ORI, i_rs, i_rt, i_imm);
            OP_LUI:  o_word = pack_i(c_OPC_LUI, c_REG_ZERO, i_rt, i_imm);
            OP_LW:   o_word = pack_i(c_OPC_LW, i_rs, i_rt, i_imm);
            OP_SW:   o_word = pack_i(c_OPC_SW, i_rs, i_rt, i_imm);
            default: o_illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/encode_instruction.sv
`default_nettype none
// ============================================================================
//  Module      : encode_instruction
//  Description : Instruction encoder and program-memory writer. Accepts one
//                symbolic instruction per handshake, packs it into a MIPS
//                word and presents it on a registered memory-write port at an
//                auto-incrementing word address.
//  Config      : ENC_BRANCH_REL_EN - relative BEQ/BNE offsets (see
//                encode_fields).
//  Ports       : clk    clock, all state on rising edge
//                reset  synchronous active-high reset
//                bus    encode_instruction_if.slave (request, memory, status)
//  Revision    : 1.0  initial release
// ============================================================================
module encode_instruction
    import mips_isa_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  wire logic             clk,
    input  wire logic             reset,
    encode_instruction_if.slave   bus
);

    localparam logic [ADDR_W-1:0] c_ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] r_wr_ptr;
    logic              r_mem_valid;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_illegal;
    logic [ADDR_W-1:0] r_words_written;

    logic              w_in_ready;
    logic              w_accept;
    logic [31:0]       w_word;
    logic              w_illegal;
    logic              w_load;

    // A new word may enter only when the output register is empty or is
    // being drained this cycle; start blocks acceptance so the pointer load
    // cannot collide with an assignment.
    assign w_in_ready = !reset && !bus.start && (!r_mem_valid || bus.mem_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_load     = w_accept && !w_illegal;

    encode_fields #(
        .ADDR_W (ADDR_W)
    ) u_encode_fields (
        .i_op_sel  (bus.op_sel),
        .i_rs      (bus.rs),
        .i_rt      (bus.rt),
        .i_rd      (bus.rd),
        .i_shamt   (bus.shamt),
        .i_imm     (bus.imm),
        .i_target  (bus.target),
        .i_addr    (r_wr_ptr),
        .o_word    (w_word),
        .o_illegal (w_illegal)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr        <= '0;
            r_mem_valid     <= 1'b0;
            r_mem_addr      <= '0;
            r_mem_wdata     <= '0;
            r_illegal       <= 1'b0;
            r_words_written <= '0;
        end else begin
            r_illegal <= w_accept && w_illegal;

            if (bus.start) begin
                r_wr_ptr        <= bus.base_addr;
                r_words_written <= '0;
            end else begin
                if (r_mem_valid && bus.mem_ready) begin
                    r_words_written <= r_words_written + c_ONE;
                end
                if (w_load) begin
                    r_wr_ptr <= r_wr_ptr + c_ONE;
                end
            end

            // An illegal request is consumed without touching the output
            // register, so a draining word still clears mem_valid.
            if (w_load) begin
                r_mem_valid <= 1'b1;
                r_mem_addr  <= r_wr_ptr;
                r_mem_wdata <= w_word;
            end else if (bus.mem_ready) begin
                r_mem_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.mem_valid     = r_mem_valid;
    assign bus.mem_addr      = r_mem_addr;
    assign bus.mem_wdata     = r_mem_wdata;
    assign bus.illegal       = r_illegal;
    assign bus.words_written = r_words_written;

endmodule
`default_nettype wire

// File: tb/tb_encode_instruction.sv
`default_nettype none
// ============================================================================
//  Module      : tb_encode_instruction
//  Description : Self-checking bench for encode_instruction: directed vector
//                table, hand-written multi-cycle sequences (illegal op,
//                back-pressure, address wrap, reset mid-stream, relative
//                branch when ENC_BRANCH_REL_EN is defined) and randomized
//                traffic compared with a behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_encode_instruction;
    localparam int ADDR_W = 10;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;

    encode_instruction_if #(.ADDR_W(ADDR_W)) bus ();

    encode_instruction #(.ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [31:0]       w;
    } mw_t;

    vec_t vt [14];
    mw_t  q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic set_req(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic [4:0] sh,
                           input logic [15:0] imm, input logic [25:0] tgt);
        bus.in_valid = 1'b1;
        bus.op_sel   = op;
        bus.rs       = rs;
        bus.rt       = rt;
        bus.rd       = rd;
        bus.shamt    = sh;
        bus.imm      = imm;
        bus.target   = tgt;
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] base);
        bus.in_valid  = 1'b1;   // start must win over a simultaneous request
        bus.start     = 1'b1;
        bus.base_addr = base;
        #1;
        chk("start_blocks_ready", 32'(bus.in_ready), 32'd0);
        tick();
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
    endtask

    // Behavioural encoding from the ISA tables using plain arithmetic.
    function automatic logic [31:0] ref_word(input int op, input int rs, input int rt,
                                             input int rd, input int sh, input int imm,
                                             input int tgt, input int addr, output bit legal);
        longint w;
        int     fn  [7] = '{0, 8, 18, 24, 32, 37, 42};
        int     opc [9] = '{4, 5, 8, 10, 12, 13, 15, 35, 43};
        int     f;
        w     = 0;
        legal = 1'b1;
        if (op <= 6) begin
            w = fn[op];
            if (op != 0 && op != 2)             w += longint'(rs) * 2097152;
            if (op == 0 || op >= 3)             w += longint'(rt) * 65536;
            if (op == 0 || op == 2 || op >= 4)  w += longint'(rd) * 2048;
            if (op == 0)                        w += longint'(sh) * 64;
        end else if (op <= 8) begin
            w = longint'(op == 7 ? 2 : 3) * 67108864 + longint'(tgt);
        end else if (op <= 17) begin
            f = imm;
`ifdef ENC_BRANCH_REL_EN
            if (op <= 10) f = ((tgt % (1 << ADDR_W)) - (addr + 1)) & 'hFFFF;
`endif
            w = longint'(opc[op-9]) * 67108864 + longint'(op == 15 ? 0 : rs) * 2097152
                + longint'(rt) * 65536 + longint'(f);
        end else begin
            legal = 1'b0;
        end
        if (addr < 0) w = 0;   // keeps addr referenced in every build
        return w[31:0];
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    logic [ADDR_W-1:0] r_ptr;
    int                ww;
    bit                exp_ill;
    bit                acc;
    bit                lg;
    logic [31:0]       ew;
    logic [4:0]        rop;

    initial begin
        vt[0]  = '{5'd11, 5'd0,  5'd8,  5'd0,  5'd0, 16'h0005, 26'h0,       32'h20080005};
        vt[1]  = '{5'd15, 5'd7,  5'd1,  5'd0,  5'd0, 16'h1001, 26'h0,       32'h3C011001};
        vt[2]  = '{5'd7,  5'd3,  5'd0,  5'd0,  5'd0, 16'h0,    26'h0100000, 32'h08100000};
        vt[3]  = '{5'd0,  5'd5,  5'd2,  5'd3,  5'd4, 16'h0,    26'h0,       32'h00021900};
        vt[4]  = '{5'd1,  5'd31, 5'd1,  5'd2,  5'd3, 16'h0,    26'h0,       32'h03E00008};
        vt[5]  = '{5'd2,  5'd1,  5'd2,  5'd12, 5'd1, 16'h0,    26'h0,       32'h00006012};
        vt[6]  = '{5'd3,  5'd4,  5'd5,  5'd6,  5'd7, 16'h0,    26'h0,       32'h00850018};
        vt[7]  = '{5'd5,  5'd1,  5'd2,  5'd3,  5'd9, 16'h0,    26'h0,       32'h00221825};
        vt[8]  = '{5'd6,  5'd16, 5'd17, 5'd18, 5'd0, 16'h0,    26'h0,       32'h0211902A};
        vt[9]  = '{5'd8,  5'd0,  5'd0,  5'd0,  5'd0, 16'h0,    26'h3FFFFFF, 32'h0FFFFFFF};
        vt[10] = '{5'd14, 5'd2,  5'd3,  5'd0,  5'd0, 16'hBEEF, 26'h0,       32'h3443BEEF};
        vt[11] = '{5'd16, 5'd29, 5'd8,  5'd0,  5'd0, 16'hFFFC, 26'h0,       32'h8FA8FFFC};
        vt[12] = '{5'd17, 5'd29, 5'd31, 5'd0,  5'd0, 16'h0004, 26'h0,       32'hAFBF0004};
        vt[13] = '{5'd13, 5'd1,  5'd1,  5'd0,  5'd0, 16'h00FF, 26'h0,       32'h302100FF};

        bus.start = 1'b0; bus.base_addr = '0; bus.in_valid = 1'b0; bus.mem_ready = 1'b1;
        bus.op_sel = '0; bus.rs = '0; bus.rt = '0; bus.rd = '0; bus.shamt = '0;
        bus.imm = '0; bus.target = '0;

        // Reset state
        reset = 1'b1;
        bus.in_valid = 1'b1;
        tick(); tick();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
        chk("rst_illegal", 32'(bus.illegal), 32'd0);
        chk("rst_words", 32'(bus.words_written), 32'd0);
        bus.in_valid = 1'b0;
        reset = 1'b0;

        // ADD, one cycle latency
        do_start('0);
        set_req(5'd4, 5'd9, 5'd10, 5'd8, 5'd3, 16'h0, 26'h0);
        #1 chk("add_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("add_valid", 32'(bus.mem_valid), 32'd1);
        chk("add_addr", 32'(bus.mem_addr), 32'd0);
        chk("add_wdata", bus.mem_wdata, 32'h012A4020);
        tick();
        chk("add_drained", 32'(bus.mem_valid), 32'd0);
        chk("add_words", 32'(bus.words_written), 32'd1);

        // Table vectors, back-to-back from address 0
        do_start('0);
        for (int i = 0; i < 14; i++) begin
            set_req(vt[i].op, vt[i].rs, vt[i].rt, vt[i].rd, vt[i].sh, vt[i].imm, vt[i].tgt);
            tick();
            chk($sformatf("vec%0d_valid", i), 32'(bus.mem_valid), 32'd1);
            chk($sformatf("vec%0d_addr", i), 32'(bus.mem_addr), 32'(i));
            chk($sformatf("vec%0d_wdata", i), bus.mem_wdata, vt[i].exp);
            chk($sformatf("vec%0d_words", i), 32'(bus.words_written), 32'(i));
        end
        bus.in_valid = 1'b0;
        tick();
        chk("vec_words_total", 32'(bus.words_written), 32'd14);

        // Illegal op between two ADDs
        do_start('0);
        set_req(5'd4, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        tick();
        chk("ill_add1_addr", 32'(bus.mem_addr), 32'd0);
        chk("ill_pre", 32'(bus.illegal), 32'd0);
        set_req(5'd31, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        tick();
        chk("ill_pulse", 32'(bus.illegal), 32'd1);
        chk("ill_no_valid", 32'(bus.mem_valid), 32'd0);
        set_req(5'd4, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0, 26'h0);
        tick();
        bus.in_valid = 1'b0;
        chk("ill_pulse_end", 32'(bus.illegal), 32'd0);
        chk("ill_add2_addr", 32'(bus.mem_addr), 32'd1);
        chk("ill_add2_wdata", bus.mem_wdata, 32'h00853020);
        tick();
        chk("ill_words", 32'(bus.words_written), 32'd2);

        // Back-pressure: mem_ready low for 3 cycles with a request waiting
        do_start(10'd5);
        bus.mem_ready = 1'b0;
        set_req(5'd5, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        tick();
        set_req(5'd6, 5'd16, 5'd17, 5'd18, 5'd0, 16'h0, 26'h0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("stall%0d_ready", i), 32'(bus.in_ready), 32'd0);
            tick();
            chk($sformatf("stall%0d_addr", i), 32'(bus.mem_addr), 32'd5);
            chk($sformatf("stall%0d_wdata", i), bus.mem_wdata, 32'h00221825);
        end
        bus.mem_ready = 1'b1;
        #1 chk("stall_release_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("stall_next_addr", 32'(bus.mem_addr), 32'd6);
        chk("stall_next_wdata", bus.mem_wdata, 32'h0211902A);
        tick();
        chk("stall_words", 32'(bus.words_written), 32'd2);

        // Address wrap
        do_start(10'd1023);
        set_req(5'd4, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0);
        tick();
        chk("wrap_addr_hi", 32'(bus.mem_addr), 32'd1023);
        tick();
        bus.in_valid = 1'b0;
        chk("wrap_addr_lo", 32'(bus.mem_addr), 32'd0);
        tick();

        // BEQ with base 4
        do_start(10'd4);
        set_req(5'd9, 5'd8, 5'd9, 5'd0, 5'd0, 16'h1234, 26'd2);
        tick();
        bus.in_valid = 1'b0;
        chk("beq_addr", 32'(bus.mem_addr), 32'd4);
`ifdef ENC_BRANCH_REL_EN
        chk("beq_wdata", bus.mem_wdata, 32'h1109FFFD);
`else
        chk("beq_wdata", bus.mem_wdata, 32'h11091234);
`endif
        tick();

        // Reset while a word is pending
        bus.mem_ready = 1'b0;
        set_req(5'd4, 5'd9, 5'd10, 5'd8, 5'd0, 16'h0, 26'h0);
        tick();
        chk("mid_pending", 32'(bus.mem_valid), 32'd1);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        tick();
        chk("mid_valid", 32'(bus.mem_valid), 32'd0);
        chk("mid_addr", 32'(bus.mem_addr), 32'd0);
        chk("mid_wdata", bus.mem_wdata, 32'd0);
        chk("mid_words", 32'(bus.words_written), 32'd0);
        chk("mid_ready", 32'(bus.in_ready), 32'd0);
        reset = 1'b0;
        bus.mem_ready = 1'b1;
        tick();

        // Randomized traffic against the model
        r_ptr   = ADDR_W'($urandom);
        do_start(r_ptr);
        ww      = 0;
        exp_ill = 1'b0;
        for (int c = 0; c < 400; c++) begin
            chk("rnd_illegal", 32'(bus.illegal), 32'(exp_ill));
            chk("rnd_valid", 32'(bus.mem_valid), 32'(q.size() != 0));
            chk("rnd_words", 32'(bus.words_written), 32'(ww % (1 << ADDR_W)));
            if (q.size() != 0) begin
                chk("rnd_addr", 32'(bus.mem_addr), 32'(q[0].a));
                chk("rnd_wdata", bus.mem_wdata, q[0].w);
            end
            bus.mem_ready = ($urandom_range(0, 3) != 0);
            rop = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(18, 31))
                                              : 5'($urandom_range(0, 17));
            set_req(rop, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                    16'($urandom), 26'($urandom));
            bus.in_valid = ($urandom_range(0, 3) != 0);
            #1;
            acc = bus.in_valid && (q.size() == 0 || bus.mem_ready);
            chk("rnd_in_ready", 32'(bus.in_ready), 32'(q.size() == 0 || bus.mem_ready));
            if (q.size() != 0 && bus.mem_ready) begin
                void'(q.pop_front());
                ww++;
            end
            exp_ill = 1'b0;
            if (acc) begin
                ew = ref_word(int'(bus.op_sel), int'(bus.rs), int'(bus.rt), int'(bus.rd),
                              int'(bus.shamt), int'(bus.imm), int'(bus.target), int'(r_ptr), lg);
                if (lg) begin
                    q.push_back('{r_ptr, ew});
                    r_ptr = r_ptr + 1'b1;
                end else begin
                    exp_ill = 1'b1;
                end
            end
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.mem_ready = 1'b1;
        if (q.size() != 0) ww++;
        tick();
        chk("rnd_final_words", 32'(bus.words_written), 32'(ww % (1 << ADDR_W)));
        chk("rnd_final_valid", 32'(bus.mem_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/encode_instruction.md
# encode_instruction

Instruction encoder and program-memory writer for the MIPS core. It accepts one symbolic instruction per handshake, made of an operation select plus register, immediate and target fields. It packs these into a 32-bit MIPS machine word and streams the word into instruction memory at an auto-incrementing word address. It is the producing end of the decoder's opcode/funct space and emits exactly the instruction subset the decoder recognises. Used by the boot/test loader to build programs in instruction memory.

## Interface
Parameters:
- ADDR_W, 10, instruction-memory word-address width

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  pulse: load write-address counter from base_addr
- base_addr  in  ADDR_W  first word address of the program
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- op_sel  in  5  operation enum (see Operation)
- rs, rt, rd, shamt  in  5 each  register and shift fields
- imm  in  16  immediate / branch offset
- target  in  26  jump target (word index); branch absolute target when ENC_BRANCH_REL_EN
- mem_valid  out  1  encoded word pending
- mem_ready  in  1  memory accepts word when mem_valid && mem_ready
- mem_addr  out  ADDR_W  word address of pending word
- mem_wdata  out  32  encoded instruction
- illegal  out  1  one-cycle pulse: accepted request had an unsupported op_sel; no word produced
- words_written  out  ADDR_W  count of words accepted by memory since reset/start, wraps

## Operation
- op_sel enum and encodings (opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0]):
  - 0 SLL: op 0, rs=0, funct 0x00. 1 JR: op 0, rs only, funct 0x08. 2 MFLO: op 0, rd only, funct 0x12. 3 MULT: op 0, rs, rt, funct 0x18. 4 ADD 0x20. 5 OR 0x25. 6 SLT 0x2A. R-type fields not used by an operation are forced to 0.
  - 7 J: op 0x02, target. 8 JAL: op 0x03, target.
  - 9 BEQ 0x04. 10 BNE 0x05. 11 ADDI 0x08. 12 SLTI 0x0A. 13 ANDI 0x0C. 14 ORI 0x0D. 15 LUI 0x0F with rs=0. 16 LW 0x23. 17 SW 0x2B. All I-types use rs, rt, imm.
  - 18–31: illegal.
- Write-address counter wr_ptr (ADDR_W bits) is assigned to each legal request at acceptance, then incremented. It wraps from 2^ADDR_W−1 to 0 silently.
- Illegal request: accepted and consumed, illegal pulses the next cycle, wr_ptr unchanged, mem_valid not raised.
- start: wr_ptr <= base_addr, words_written <= 0. in_ready forced low in a start cycle, so start wins over a simultaneous in_valid. A word already pending on mem_* completes normally with its original address.
- words_written increments on each mem_valid && mem_ready.

## Timing
- Reset values: in_ready 0 during reset; mem_valid 0, mem_addr 0, mem_wdata 0, illegal 0, words_written 0, wr_ptr 0.
- in_ready = !reset && !start && (!mem_valid || mem_ready). Full throughput is one word per cycle.
- Latency: request accepted in cycle N gives mem_valid/mem_addr/mem_wdata registered in cycle N+1.
- While mem_valid && !mem_ready, mem_addr and mem_wdata hold stable and in_ready is 0.
- Reset asserted mid-stream drops any pending word; no partial write is reported.

## Configuration
- ENC_BRANCH_REL_EN defined: for BEQ/BNE, imm is ignored. target[ADDR_W-1:0] is an absolute word address, and the encoded offset is target − (assigned address + 1), truncated to 16 bits in two's complement. ADDR_W ≤ 16 is required.
- Not defined: BEQ/BNE encode imm verbatim; target is used by J/JAL only.

## Structure
- Shared package mips_isa_pkg: op_sel enum, opcode and funct localparams, field bit positions. The decoder imports the same package.
- One combinational sub-module, encode_fields: takes op_sel, fields and the assigned address; returns word[31:0] and illegal. The top holds the handshake, wr_ptr, output register and counters.

## Test plan
- ADD rd=8 rs=9 rt=10 after start with base_addr=0 -> mem_wdata 0x012A4020, mem_addr 0, one cycle after acceptance.
- ADDI rt=8 rs=0 imm=5, then LUI rt=1 imm=0x1001, then J target=0x0100000, back-to-back with mem_ready=1 -> 0x20080005, 0x3C011001, 0x08100000 at addresses 0,1,2 on consecutive cycles; words_written=3.
- ENC_BRANCH_REL_EN, base_addr=4, BEQ rs=8 rt=9 target=2 -> mem_wdata 0x1109FFFD at mem_addr 4.
- op_sel=31 between two ADDs -> illegal pulse of 1 cycle; ADDs land at consecutive addresses; no mem_valid for the illegal request.
- mem_ready held low 3 cycles with in_valid high -> mem_wdata/mem_addr stable, in_ready 0; next request is written only after mem_ready rises.
- ADDR_W=10, base_addr=1023, two requests -> addresses 1023 then 0. Also: reset while mem_valid is high -> all outputs 0 on the next cycle.
